// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase sequencer: NS/EW green arbitration with min/max green,
// fixed yellow/all-red clearance and a latched pedestrian walk phase.
module intersection_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int PED_T     = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_ALL_RED = 3'd0,
        S_NS_G    = 3'd1,
        S_NS_Y    = 3'd2,
        S_EW_G    = 3'd3,
        S_EW_Y    = 3'd4,
        S_WALK    = 3'd5
    } state_t;

    // Exit thresholds: a state of duration D leaves when the elapsed count reaches D-1.
    localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] L_PED  = CNT_W'(PED_T - 1);
    localparam logic [CNT_W-1:0] L_SAT  = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped_wait;
    logic             r_last_ew;
    logic             r_from_walk;

    state_t           w_state_next;
    logic             w_last_ew_next;
    logic             w_from_walk_next;
    logic             w_demand_ns;
    logic             w_demand_ew;
    logic             w_enter_walk;

    // Demand for the opposing phase includes a waiting pedestrian.
    assign w_demand_ns  = ns_car || r_ped_wait;
    assign w_demand_ew  = ew_car || r_ped_wait;
    assign w_enter_walk = (w_state_next == S_WALK) && (r_state != S_WALK);

    always_comb begin
        w_state_next     = r_state;
        w_last_ew_next   = r_last_ew;
        w_from_walk_next = r_from_walk;
        case (r_state)
            S_ALL_RED: begin
                if (r_cnt == L_AR) begin
                    if (r_ped_wait && !r_from_walk) begin
                        w_state_next = S_WALK;
                    end else if (r_last_ew) begin
                        w_state_next   = S_NS_G;
                        w_last_ew_next = 1'b0;
                    end else begin
                        w_state_next   = S_EW_G;
                        w_last_ew_next = 1'b1;
                    end
                end
            end
            S_NS_G: begin
                if (r_cnt >= L_GMIN && w_demand_ew && (!ns_car || r_cnt >= L_GMAX))
                    w_state_next = S_NS_Y;
            end
            S_EW_G: begin
                if (r_cnt >= L_GMIN && w_demand_ns && (!ew_car || r_cnt >= L_GMAX))
                    w_state_next = S_EW_Y;
            end
            S_NS_Y, S_EW_Y: begin
                if (r_cnt == L_YEL) begin
                    w_state_next     = S_ALL_RED;
                    w_from_walk_next = 1'b0;
                end
            end
            S_WALK: begin
                if (r_cnt == L_PED) begin
                    w_state_next     = S_ALL_RED;
                    w_from_walk_next = 1'b1;
                end
            end
            default: w_state_next = S_ALL_RED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_ALL_RED;
            r_cnt       <= '0;
            r_ped_wait  <= 1'b0;
            r_last_ew   <= 1'b1;
            r_from_walk <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_last_ew   <= w_last_ew_next;
            r_from_walk <= w_from_walk_next;
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != L_SAT)
                r_cnt <= r_cnt + 1'b1;
            // Entering WALK serves the request and beats a simultaneous new press.
            if (w_enter_walk)
                r_ped_wait <= 1'b0;
            else if (ped_req && r_state != S_WALK)
                r_ped_wait <= 1'b1;
        end
    end

    always_comb begin
        ns_lights = 3'b100;
        ew_lights = 3'b100;
        walk      = 1'b0;
        case (r_state)
            S_NS_G:  ns_lights = 3'b001;
            S_NS_Y:  ns_lights = 3'b010;
            S_EW_G:  ew_lights = 3'b001;
            S_EW_Y:  ew_lights = 3'b010;
            S_WALK:  walk      = 1'b1;
            default: ;
        endcase
    end

    assign ped_wait = r_ped_wait;
    assign phase    = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with hand-computed light sequences.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ns_car, ew_car, ped_req;
    logic [2:0] ns_lights, ew_lights, phase;
    logic       walk, ped_wait;

    int n_cmp = 0;
    int n_err = 0;

    intersection_phase_scheduler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ns_car    (ns_car),
        .ew_car    (ew_car),
        .ped_req   (ped_req),
        .ns_lights (ns_lights),
        .ew_lights (ew_lights),
        .walk      (walk),
        .ped_wait  (ped_wait),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and release, leaving the bench in the first NS_G cycle.
    task automatic go_ns_g();
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
        reset_n = 1'b0;
        step(); step();
        n_cmp++;
        if ({ns_lights, ew_lights, walk, ped_wait, phase} !== {3'b100, 3'b100, 1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: got ns=%b ew=%b walk=%b pw=%b ph=%0d, want 100 100 0 0 0",
                     ns_lights, ew_lights, walk, ped_wait, phase);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (phase !== 3'd0) begin
            n_err++;
            $display("FAIL release_allred: got phase=%0d want 0", phase);
        end
        step();
        n_cmp++;
        if ({ns_lights, ew_lights, phase} !== {3'b001, 3'b100, 3'd1}) begin
            n_err++;
            $display("FAIL first_ns_green: got ns=%b ew=%b ph=%0d want 001 100 1", ns_lights, ew_lights, phase);
        end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_hold_green();
        int bad = 0;
        go_ns_g();
        for (int i = 0; i < 50; i++) begin
            if ({ns_lights, ew_lights} !== {3'b001, 3'b100}) bad++;
            step();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL hold_green: got %0d non-green cycles want 0", bad);
        end
        $display("test_hold_green done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_ew_demand();
        logic [5:0] exp_tab [8] = '{6'b001_100, 6'b001_100, 6'b001_100, 6'b001_100,
                                    6'b010_100, 6'b010_100, 6'b100_100, 6'b100_001};
        go_ns_g();
        ew_car = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({ns_lights, ew_lights} !== exp_tab[i]) begin
                n_err++;
                $display("FAIL ew_demand[%0d]: got %b_%b want %b", i, ns_lights, ew_lights, exp_tab[i]);
            end
            step();
        end
        $display("test_ew_demand done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_max_green();
        int n;
        go_ns_g();
        ns_car = 1'b1;
        ew_car = 1'b1;
        n = 0;
        while (ns_lights === 3'b001 && n < 40) begin
            n++;
            step();
        end
        n_cmp++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL ns_max_green: got %0d cycles want 12", n);
        end
        n_cmp++;
        if (ns_lights !== 3'b010) begin
            n_err++;
            $display("FAIL ns_max_yellow: got ns=%b want 010", ns_lights);
        end
        step(); step(); step();
        n_cmp++;
        if ({ew_lights, phase} !== {3'b001, 3'd3}) begin
            n_err++;
            $display("FAIL ew_green_entry: got ew=%b ph=%0d want 001 3", ew_lights, phase);
        end
        n = 0;
        while (ew_lights === 3'b001 && n < 40) begin
            n++;
            step();
        end
        n_cmp++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL ew_max_green: got %0d cycles want 12", n);
        end
        n_cmp++;
        if (ew_lights !== 3'b010) begin
            n_err++;
            $display("FAIL ew_max_yellow: got ew=%b want 010", ew_lights);
        end
        $display("test_max_green done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_ped_walk();
        // {phase, ns, ew, walk, ped_wait}
        logic [10:0] exp_tab [14] = '{
            {3'd1, 3'b001, 3'b100, 1'b0, 1'b1}, {3'd1, 3'b001, 3'b100, 1'b0, 1'b1},
            {3'd1, 3'b001, 3'b100, 1'b0, 1'b1}, {3'd2, 3'b010, 3'b100, 1'b0, 1'b1},
            {3'd2, 3'b010, 3'b100, 1'b0, 1'b1}, {3'd0, 3'b100, 3'b100, 1'b0, 1'b1},
            {3'd5, 3'b100, 3'b100, 1'b1, 1'b0}, {3'd5, 3'b100, 3'b100, 1'b1, 1'b0},
            {3'd5, 3'b100, 3'b100, 1'b1, 1'b0}, {3'd5, 3'b100, 3'b100, 1'b1, 1'b0},
            {3'd5, 3'b100, 3'b100, 1'b1, 1'b0}, {3'd5, 3'b100, 3'b100, 1'b1, 1'b0},
            {3'd0, 3'b100, 3'b100, 1'b0, 1'b0}, {3'd3, 3'b100, 3'b001, 1'b0, 1'b0}};
        go_ns_g();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 0; i < 14; i++) begin
            n_cmp++;
            if ({phase, ns_lights, ew_lights, walk, ped_wait} !== exp_tab[i]) begin
                n_err++;
                $display("FAIL ped_walk[%0d]: got ph=%0d ns=%b ew=%b walk=%b pw=%b want %b",
                         i, phase, ns_lights, ew_lights, walk, ped_wait, exp_tab[i]);
            end
            ped_req = (i == 7);
            step();
        end
        ped_req = 1'b0;
        $display("test_ped_walk done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_async_reset();
        int n;
        go_ns_g();
        ew_car = 1'b1;
        n = 0;
        while (phase !== 3'd3 && n < 20) begin
            n++;
            step();
        end
        n_cmp++;
        if (phase !== 3'd3) begin
            n_err++;
            $display("FAIL reach_ew_green: got ph=%0d want 3", phase);
        end
        ped_req = 1'b1;
        ew_car  = 1'b0;
        step();
        ped_req = 1'b0;
        n = 0;
        while (phase !== 3'd4 && n < 20) begin
            n++;
            step();
        end
        n_cmp++;
        if ({phase, ped_wait} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL reach_ew_yellow: got ph=%0d pw=%b want 4 1", phase, ped_wait);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ns_lights, ew_lights, walk, ped_wait, phase} !== {3'b100, 3'b100, 1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL async_reset: got ns=%b ew=%b walk=%b pw=%b ph=%0d want 100 100 0 0 0",
                     ns_lights, ew_lights, walk, ped_wait, phase);
        end
        step(); step();
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (phase !== 3'd0) begin
            n_err++;
            $display("FAIL restart_allred: got ph=%0d want 0", phase);
        end
        step();
        n_cmp++;
        if ({ns_lights, ew_lights, phase, ped_wait} !== {3'b001, 3'b100, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL restart_ns_green: got ns=%b ew=%b ph=%0d pw=%b want 001 100 1 0",
                     ns_lights, ew_lights, phase, ped_wait);
        end
        $display("test_async_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    initial begin
        test_reset();
        test_hold_green();
        test_ew_demand();
        test_max_green();
        test_ped_walk();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
